branch_predictor_param: RTL and testbench

- Parametrised successor to the fixed-table ID-stage branch predictor: table of N-bit saturating counters.
- Selectable bimodal or gshare indexing, with a commit-time global history register and saturating statistics counters.
- Sits beside the decode stage; the decode lookup is combinational.
- Training comes from the branch-correction path when a branch resolves (EX/MEM).

---
 rtl/branch_predictor_param_if.sv | 34 +++
 rtl/branch_predictor_param.sv | 103 ++++++++++
 tb/tb_branch_predictor_param.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_param_if.sv
// Decode-side lookup, resolve-side update and debug/statistics bundle
// for the parametrised branch predictor.
interface branch_predictor_param_if #(
    parameter int IDX_BITS = 6,
    parameter int HIST_LEN = 6,
    parameter int STAT_W   = 16
);
    logic                lk_valid;
    logic [29:0]         lk_pc;
    logic [2:0]          lk_branchType;
    logic                lk_predict;
    logic [IDX_BITS-1:0] lk_index;
    logic                upd_valid;
    logic [IDX_BITS-1:0] upd_index;
    logic                upd_taken;
    logic                upd_mispredict;
    logic [STAT_W-1:0]   stat_lookups;
    logic [STAT_W-1:0]   stat_mispredicts;
    logic [HIST_LEN-1:0] ghr;

    modport master (
        output lk_valid, lk_pc, lk_branchType,
        output upd_valid, upd_index, upd_taken, upd_mispredict,
        input  lk_predict, lk_index,
        input  stat_lookups, stat_mispredicts, ghr
    );

    modport slave (
        input  lk_valid, lk_pc, lk_branchType,
        input  upd_valid, upd_index, upd_taken, upd_mispredict,
        output lk_predict, lk_index,
        output stat_lookups, stat_mispredicts, ghr
    );
endinterface

// File: rtl/branch_predictor_param.sv
// Saturating-counter branch predictor with bimodal or gshare indexing,
// commit-time global history and saturating statistics.
module branch_predictor_param #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 2,
    parameter int MODE     = 0,
    parameter int HIST_LEN = 6,
    parameter int STAT_W   = 16
) (
    input logic clk,
    input logic rst,
    branch_predictor_param_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((1 << (CNT_W - 1)) - 1);

    if (IDX_BITS < 2 || IDX_BITS > 12) begin : g_bad_idx
        $error("IDX_BITS out of range 2..12");
    end
    if (CNT_W < 1 || CNT_W > 4) begin : g_bad_cnt
        $error("CNT_W out of range 1..4");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("MODE must be 0 or 1");
    end
    if (HIST_LEN < 1 || HIST_LEN > IDX_BITS) begin : g_bad_hist
        $error("HIST_LEN out of range 1..IDX_BITS");
    end
    if (STAT_W < 1) begin : g_bad_stat
        $error("STAT_W must be positive");
    end

    logic [CNT_W-1:0]    table_q [ENTRIES];
    logic [HIST_LEN-1:0] ghr_q, ghr_d, ghr_shift;
    logic [STAT_W-1:0]   lookups_q, lookups_d;
    logic [STAT_W-1:0]   mispred_q, mispred_d;
    logic [CNT_W-1:0]    cur_cnt, nxt_cnt;
    logic [IDX_BITS-1:0] lk_idx;
    logic                is_branch;

    // Bits of the PC above the index never take part in the lookup.
    logic unused_pc;
    assign unused_pc = ^bp.lk_pc;

    if (MODE == 1) begin : g_gshare
        assign lk_idx = bp.lk_pc[IDX_BITS-1:0] ^ IDX_BITS'(ghr_q);
    end else begin : g_bimodal
        assign lk_idx = bp.lk_pc[IDX_BITS-1:0];
    end

    if (HIST_LEN == 1) begin : g_hist1
        assign ghr_shift = bp.upd_taken;
    end else begin : g_histn
        assign ghr_shift = {ghr_q[HIST_LEN-2:0], bp.upd_taken};
    end

    assign is_branch     = (bp.lk_branchType != 3'd0);
    assign bp.lk_index   = lk_idx;
    assign bp.lk_predict = table_q[lk_idx][CNT_W-1] & is_branch;
    assign bp.ghr              = ghr_q;
    assign bp.stat_lookups     = lookups_q;
    assign bp.stat_mispredicts = mispred_q;

    always_comb begin
        cur_cnt   = table_q[bp.upd_index];
        nxt_cnt   = cur_cnt;
        ghr_d     = ghr_q;
        lookups_d = lookups_q;
        mispred_d = mispred_q;
        if (bp.upd_taken) begin
            if (cur_cnt != CNT_MAX) nxt_cnt = cur_cnt + CNT_W'(1);
        end else begin
            if (cur_cnt != '0) nxt_cnt = cur_cnt - CNT_W'(1);
        end
        if (bp.upd_valid) ghr_d = ghr_shift;
        if (bp.lk_valid && is_branch && lookups_q != '1)
            lookups_d = lookups_q + STAT_W'(1);
        if (bp.upd_valid && bp.upd_mispredict && mispred_q != '1)
            mispred_d = mispred_q + STAT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
        end else if (bp.upd_valid) begin
            table_q[bp.upd_index] <= nxt_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q     <= '0;
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor_param.sv
// Bench: bimodal (default) and gshare/STAT_W=3 instances checked against
// an arithmetic model every cycle, plus hand-computed directed checks.
module tb_branch_predictor_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_param_if #(.IDX_BITS(6), .HIST_LEN(6), .STAT_W(16)) a ();
    branch_predictor_param_if #(.IDX_BITS(6), .HIST_LEN(4), .STAT_W(3))  b ();

    branch_predictor_param #(
        .IDX_BITS(6), .CNT_W(2), .MODE(0), .HIST_LEN(6), .STAT_W(16)
    ) dut_a (.clk(clk), .rst(rst), .bp(a));

    branch_predictor_param #(
        .IDX_BITS(6), .CNT_W(2), .MODE(1), .HIST_LEN(4), .STAT_W(3)
    ) dut_b (.clk(clk), .rst(rst), .bp(b));

    int checks = 0;
    int failures = 0;
    bit run = 0;

    // Model state: counter values as plain integers 0..3.
    int tbl [2][64];
    int ghr_m [2];
    int sl [2];
    int sm [2];
    int hl [2] = '{6, 4};
    int sw [2] = '{16, 3};
    int md [2] = '{0, 1};

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eidx(int k, int pc);
        return md[k] ? ((pc & 63) ^ ghr_m[k]) : (pc & 63);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) tbl[k][i] = 1;
            ghr_m[k] = 0;
            sl[k] = 0;
            sm[k] = 0;
        end
    endfunction

    function automatic void model_step(int k, int lv, int bt, int uv,
                                       int ui, int ut, int um);
        int smax;
        smax = (1 << sw[k]) - 1;
        if (lv != 0 && bt != 0 && sl[k] < smax) sl[k]++;
        if (uv != 0 && um != 0 && sm[k] < smax) sm[k]++;
        if (uv != 0) begin
            if (ut != 0) tbl[k][ui] = (tbl[k][ui] < 3) ? tbl[k][ui] + 1 : 3;
            else         tbl[k][ui] = (tbl[k][ui] > 0) ? tbl[k][ui] - 1 : 0;
            ghr_m[k] = ((ghr_m[k] * 2) + ut) % (1 << hl[k]);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0, a.lk_valid, a.lk_branchType, a.upd_valid,
                       a.upd_index, a.upd_taken, a.upd_mispredict);
            model_step(1, b.lk_valid, b.lk_branchType, b.upd_valid,
                       b.upd_index, b.upd_taken, b.upd_mispredict);
        end
    end

    task automatic cmp(int k, int pc, int bt, int pr, int ix,
                       int s1, int s2, int g);
        int e;
        e = eidx(k, pc);
        chk($sformatf("m%0d_index", k), ix, e);
        chk($sformatf("m%0d_predict", k), pr, (tbl[k][e] >= 2 && bt != 0) ? 1 : 0);
        chk($sformatf("m%0d_stat_lookups", k), s1, sl[k]);
        chk($sformatf("m%0d_stat_mispredicts", k), s2, sm[k]);
        chk($sformatf("m%0d_ghr", k), g, ghr_m[k]);
    endtask

    always @(negedge clk) begin
        if (run) begin
            cmp(0, a.lk_pc, a.lk_branchType, a.lk_predict, a.lk_index,
                a.stat_lookups, a.stat_mispredicts, a.ghr);
            cmp(1, b.lk_pc, b.lk_branchType, b.lk_predict, b.lk_index,
                b.stat_lookups, b.stat_mispredicts, b.ghr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_a(int ix, bit t);
        a.upd_valid = 1'b1;
        a.upd_index = 6'(ix);
        a.upd_taken = t;
        a.upd_mispredict = 1'b0;
        tick();
        a.upd_valid = 1'b0;
    endtask

    task automatic look_a(int pc, int bt, bit v);
        a.lk_pc = 30'(pc);
        a.lk_branchType = 3'(bt);
        a.lk_valid = v;
        #1;
    endtask

    task automatic clear_inputs();
        a.lk_valid = 0; a.lk_pc = '0; a.lk_branchType = '0;
        a.upd_valid = 0; a.upd_index = '0; a.upd_taken = 0; a.upd_mispredict = 0;
        b.lk_valid = 0; b.lk_pc = '0; b.lk_branchType = '0;
        b.upd_valid = 0; b.upd_index = '0; b.upd_taken = 0; b.upd_mispredict = 0;
    endtask

    initial begin
        bit tk [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit mp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        model_reset();
        rst = 1'b1;
        clear_inputs();
        #1 run = 1;
        #11 rst = 1'b0;

        // Reset state and first lookup
        tick();
        look_a('h10, 1, 1);
        chk("t1_predict", a.lk_predict, 0);
        chk("t1_index", a.lk_index, 'h10);
        tick();
        chk("t1_stat_after_branch", a.stat_lookups, 1);
        look_a('h10, 0, 1);
        chk("t1_predict_nonbranch", a.lk_predict, 0);
        tick();
        chk("t1_stat_nonbranch", a.stat_lookups, 1);
        for (int i = 0; i < 64; i++) begin
            look_a(i, 1, 0);
            chk($sformatf("t1_weak_nt_%0d", i), a.lk_predict, 0);
        end

        // Training and aliasing
        tick();
        upd_a('h10, 1);
        upd_a('h10, 1);
        look_a('h10, 1, 0);
        chk("t2_predict_0x10", a.lk_predict, 1);
        look_a('h50, 1, 0);
        chk("t2_alias_0x50", a.lk_predict, 1);
        chk("t2_alias_index", a.lk_index, 'h10);
        look_a('h11, 1, 0);
        chk("t2_predict_0x11", a.lk_predict, 0);

        // Saturation at both ends
        repeat (5) upd_a('h10, 1);
        look_a('h10, 1, 0);
        chk("t3_sat_hi", a.lk_predict, 1);
        upd_a('h10, 0);
        look_a('h10, 1, 0);
        chk("t3_down_to_2", a.lk_predict, 1);
        upd_a('h10, 0);
        upd_a('h10, 0);
        look_a('h10, 1, 0);
        chk("t3_down_to_0", a.lk_predict, 0);
        upd_a('h10, 0);
        upd_a('h10, 1);
        look_a('h10, 1, 0);
        chk("t3_sat_lo_then_1", a.lk_predict, 0);
        upd_a('h10, 1);
        look_a('h10, 1, 0);
        chk("t3_back_to_2", a.lk_predict, 1);

        // Same-cycle read/write sees the old counter
        a.upd_valid = 1'b1;
        a.upd_index = 6'd5;
        a.upd_taken = 1'b1;
        look_a(5, 1, 0);
        chk("t4_same_cycle", a.lk_predict, 0);
        tick();
        a.upd_valid = 1'b0;
        #1;
        chk("t4_next_cycle", a.lk_predict, 1);

        // Random traffic on both instances
        for (int n = 0; n < 600; n++) begin
            tick();
            a.lk_valid = 1'($urandom);
            a.lk_pc = 30'($urandom);
            a.lk_branchType = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom);
            a.upd_valid = 1'($urandom);
            a.upd_index = 6'($urandom);
            a.upd_taken = 1'($urandom);
            a.upd_mispredict = 1'($urandom);
            b.lk_valid = 1'($urandom);
            b.lk_pc = 30'($urandom);
            b.lk_branchType = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom);
            b.upd_valid = 1'($urandom);
            b.upd_index = 6'($urandom);
            b.upd_taken = ($urandom_range(0, 3) != 0);
            b.upd_mispredict = 1'($urandom);
        end

        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Statistics saturation on the STAT_W=3 instance
        b.lk_valid = 1'b1;
        b.lk_branchType = 3'd1;
        b.lk_pc = 30'h20;
        repeat (9) tick();
        chk("t6_stat_lookups_sat", b.stat_lookups, 7);
        b.lk_valid = 1'b0;

        // gshare history and index
        for (int i = 0; i < 4; i++) begin
            b.upd_valid = 1'b1;
            b.upd_index = 6'h2B;
            b.upd_taken = tk[i];
            b.upd_mispredict = mp[i];
            tick();
        end
        b.upd_valid = 1'b0;
        #1;
        chk("t5_ghr", b.ghr, 4'b1011);
        chk("t5_gshare_index", b.lk_index, 'h2B);
        chk("t5_gshare_predict", b.lk_predict, 1);
        chk("t6_stat_mispredicts", b.stat_mispredicts, 3);

        // Async reset mid-cycle, with an update in flight
        b.upd_valid = 1'b1;
        b.upd_index = 6'h20;
        b.upd_taken = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("t6_async_lookups", b.stat_lookups, 0);
        chk("t6_async_mispredicts", b.stat_mispredicts, 0);
        chk("t6_async_ghr", b.ghr, 0);
        chk("t6_async_index", b.lk_index, 'h20);
        chk("t6_async_predict", b.lk_predict, 0);
        chk("t6_async_a_lookups", a.stat_lookups, 0);
        tick();
        rst = 1'b0;
        b.upd_valid = 1'b0;
        #1;
        chk("t6_update_lost", b.lk_predict, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
